// File: rtl/stack_cpu_core.sv
// stack_cpu_core: parametrised stack CPU with data/return stacks and traps.
// Defining STACK_CPU_MUL_EN makes opcode 0x10 a MUL; otherwise it is illegal.
module stack_cpu_core #(
  parameter int DW           = 16,
  parameter int AW           = 11,
  parameter int DSTACK_DEPTH = 32,
  parameter int RSTACK_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [AW-1:0]                 imem_addr,
  output logic                          imem_rd,
  input  logic [AW+4:0]                 imem_rdata,
  output logic [AW-1:0]                 dmem_addr,
  output logic                          dmem_rd,
  output logic                          dmem_wr,
  output logic [DW-1:0]                 dmem_wdata,
  input  logic [DW-1:0]                 dmem_rdata,
  output logic                          halted,
  output logic                          fault,
  output logic [2:0]                    fault_code,
  output logic [$clog2(DSTACK_DEPTH):0] dsp
);
  localparam int DPW = $clog2(DSTACK_DEPTH);
  localparam int RPW = $clog2(RSTACK_DEPTH);

  localparam logic [4:0] OP_NOP   = 5'h00;
  localparam logic [4:0] OP_PUSHI = 5'h01;
  localparam logic [4:0] OP_PUSHM = 5'h02;
  localparam logic [4:0] OP_POPM  = 5'h03;
  localparam logic [4:0] OP_JMP   = 5'h04;
  localparam logic [4:0] OP_JZ    = 5'h05;
  localparam logic [4:0] OP_CALL  = 5'h06;
  localparam logic [4:0] OP_RET   = 5'h07;
  localparam logic [4:0] OP_ADD   = 5'h08;
  localparam logic [4:0] OP_SUB   = 5'h09;
  localparam logic [4:0] OP_AND   = 5'h0A;
  localparam logic [4:0] OP_OR    = 5'h0B;
  localparam logic [4:0] OP_XOR   = 5'h0C;
  localparam logic [4:0] OP_NOT   = 5'h0D;
  localparam logic [4:0] OP_DUP   = 5'h0E;
`ifdef STACK_CPU_MUL_EN
  localparam logic [4:0] OP_MUL   = 5'h10;
`endif
  localparam logic [4:0] OP_HALT  = 5'h1F;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEMRD, S_HALT, S_FAULT
  } state_t;

  state_t         r_state, w_nstate;
  logic [AW-1:0]  r_pc, w_pc_nxt;
  logic [AW+4:0]  r_ir;
  logic [DPW:0]   r_dsp, w_dsp_nxt;
  logic [RPW:0]   r_rsp, w_rsp_nxt;
  logic [2:0]     r_fc, w_fc;
  logic [DW-1:0]  r_dstk [DSTACK_DEPTH];
  logic [AW-1:0]  r_rstk [RSTACK_DEPTH];

  logic [4:0]     w_op;
  logic [AW-1:0]  w_arg, w_rtop;
  logic [DW-1:0]  w_imm, w_t, w_n, w_alu, w_dwval;
  logic [DPW-1:0] w_ti, w_ni, w_dwidx;
  logic           w_dfull, w_dlt1, w_dlt2, w_rfull, w_rempty;
  logic           w_bin, w_ird, w_drd, w_dwr;
  logic           w_dwe, w_rwe, w_irwe, w_flt;
  logic [2:0]     w_fval;

  assign w_op     = r_ir[AW+4:AW];
  assign w_arg    = r_ir[AW-1:0];
  assign w_imm    = DW'(w_arg);
  assign w_ti     = r_dsp[DPW-1:0] - DPW'(1);
  assign w_ni     = r_dsp[DPW-1:0] - DPW'(2);
  assign w_t      = r_dstk[w_ti];
  assign w_n      = r_dstk[w_ni];
  assign w_rtop   = r_rstk[r_rsp[RPW-1:0] - RPW'(1)];
  assign w_dfull  = (r_dsp == (DPW+1)'(DSTACK_DEPTH));
  assign w_dlt1   = (r_dsp == '0);
  assign w_dlt2   = (r_dsp < (DPW+1)'(2));
  assign w_rfull  = (r_rsp == (RPW+1)'(RSTACK_DEPTH));
  assign w_rempty = (r_rsp == '0);

  always_comb begin
    w_alu = '0;
    w_bin = 1'b1;
    case (w_op)
      OP_ADD:  w_alu = w_n + w_t;
      OP_SUB:  w_alu = w_n - w_t;
      OP_AND:  w_alu = w_n & w_t;
      OP_OR:   w_alu = w_n | w_t;
      OP_XOR:  w_alu = w_n ^ w_t;
`ifdef STACK_CPU_MUL_EN
      OP_MUL:  w_alu = w_n * w_t;
`endif
      default: w_bin = 1'b0;
    endcase
  end

  always_comb begin
    w_nstate  = r_state;
    w_pc_nxt  = r_pc;
    w_dsp_nxt = r_dsp;
    w_rsp_nxt = r_rsp;
    w_fc      = r_fc;
    w_ird     = 1'b0;
    w_drd     = 1'b0;
    w_dwr     = 1'b0;
    w_dwe     = 1'b0;
    w_rwe     = 1'b0;
    w_irwe    = 1'b0;
    w_flt     = 1'b0;
    w_fval    = 3'd0;
    w_dwidx   = r_dsp[DPW-1:0];
    w_dwval   = w_imm;
    unique case (r_state)
      S_FETCH: begin
        w_ird    = 1'b1;
        w_nstate = S_DECODE;
      end
      S_DECODE: begin
        w_irwe   = 1'b1;
        w_pc_nxt = r_pc + AW'(1);
        w_nstate = S_EXEC;
      end
      S_EXEC: begin
        w_nstate = S_FETCH;
        case (w_op)
          OP_NOP: begin end
          OP_PUSHI: begin
            if (w_dfull) begin w_flt = 1'b1; w_fval = 3'd1; end
            else begin w_dwe = 1'b1; w_dsp_nxt = r_dsp + 1'b1; end
          end
          OP_PUSHM: begin
            if (w_dfull) begin w_flt = 1'b1; w_fval = 3'd1; end
            else begin w_drd = 1'b1; w_nstate = S_MEMRD; end
          end
          OP_POPM: begin
            if (w_dlt1) begin w_flt = 1'b1; w_fval = 3'd2; end
            else begin w_dwr = 1'b1; w_dsp_nxt = r_dsp - 1'b1; end
          end
          OP_JMP: w_pc_nxt = w_arg;
          OP_JZ: begin
            if (w_dlt1) begin w_flt = 1'b1; w_fval = 3'd2; end
            else begin
              w_dsp_nxt = r_dsp - 1'b1;
              if (w_t == '0) w_pc_nxt = w_arg;
            end
          end
          OP_CALL: begin
            if (w_rfull) begin w_flt = 1'b1; w_fval = 3'd3; end
            else begin
              w_rwe     = 1'b1;
              w_rsp_nxt = r_rsp + 1'b1;
              w_pc_nxt  = w_arg;
            end
          end
          OP_RET: begin
            if (w_rempty) begin w_flt = 1'b1; w_fval = 3'd4; end
            else begin w_rsp_nxt = r_rsp - 1'b1; w_pc_nxt = w_rtop; end
          end
          OP_NOT: begin
            if (w_dlt1) begin w_flt = 1'b1; w_fval = 3'd2; end
            else begin w_dwe = 1'b1; w_dwidx = w_ti; w_dwval = ~w_t; end
          end
          OP_DUP: begin
            if (w_dlt1) begin w_flt = 1'b1; w_fval = 3'd2; end
            else if (w_dfull) begin w_flt = 1'b1; w_fval = 3'd1; end
            else begin
              w_dwe     = 1'b1;
              w_dwval   = w_t;
              w_dsp_nxt = r_dsp + 1'b1;
            end
          end
          OP_HALT: w_nstate = S_HALT;
          default: begin
            // result lands where N was; one net pop
            if (!w_bin) begin w_flt = 1'b1; w_fval = 3'd5; end
            else if (w_dlt2) begin w_flt = 1'b1; w_fval = 3'd2; end
            else begin
              w_dwe     = 1'b1;
              w_dwidx   = w_ni;
              w_dwval   = w_alu;
              w_dsp_nxt = r_dsp - 1'b1;
            end
          end
        endcase
        if (w_flt) begin
          w_nstate = S_FAULT;
          w_fc     = w_fval;
        end
      end
      S_MEMRD: begin
        w_dwe     = 1'b1;
        w_dwval   = dmem_rdata;
        w_dsp_nxt = r_dsp + 1'b1;
        w_nstate  = S_FETCH;
      end
      default: begin end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_nstate;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc  <= '0;
      r_ir  <= '0;
      r_dsp <= '0;
      r_rsp <= '0;
      r_fc  <= '0;
    end else begin
      r_pc  <= w_pc_nxt;
      if (w_irwe) r_ir <= imem_rdata;
      r_dsp <= w_dsp_nxt;
      r_rsp <= w_rsp_nxt;
      r_fc  <= w_fc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_dwe) r_dstk[w_dwidx] <= w_dwval;
    if (!rst && w_rwe) r_rstk[r_rsp[RPW-1:0]] <= r_pc;
  end

  assign imem_addr  = r_pc;
  assign imem_rd    = w_ird & ~rst;
  assign dmem_addr  = w_arg;
  assign dmem_rd    = w_drd & ~rst;
  assign dmem_wr    = w_dwr & ~rst;
  assign dmem_wdata = w_t;
  assign halted     = (r_state == S_HALT);
  assign fault      = (r_state == S_FAULT);
  assign fault_code = r_fc;
  assign dsp        = r_dsp;
endmodule

// File: tb/tb_stack_cpu_core.sv
// tb_stack_cpu_core: instruction-level reference model checked every cycle,
// plus directed programs with hand-computed results.
module tb_stack_cpu_core;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] imem_addr;
  logic        imem_rd;
  logic [15:0] imem_rdata = '0;
  logic [10:0] dmem_addr;
  logic        dmem_rd;
  logic        dmem_wr;
  logic [15:0] dmem_wdata;
  logic [15:0] dmem_rdata = '0;
  logic        halted;
  logic        fault;
  logic [2:0]  fault_code;
  logic [5:0]  dsp;

  int checks = 0;
  int failures = 0;

  logic [15:0] prog   [0:2047];
  logic [15:0] mem    [0:2047];
  logic        mvalid [0:2047];

`ifdef STACK_CPU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  stack_cpu_core #(
    .DW(16), .AW(11), .DSTACK_DEPTH(32), .RSTACK_DEPTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .halted(halted), .fault(fault), .fault_code(fault_code), .dsp(dsp)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ins(input logic [4:0] op, input int a);
    return {op, 11'(a)};
  endfunction

  // unwritten data locations read back as 0xC000 | address
  function automatic logic [15:0] rd_mem(input logic [10:0] a);
    return (mvalid[a] === 1'b1) ? mem[a] : (16'hC000 | {5'd0, a});
  endfunction

  always @(posedge clk) begin
    if (imem_rd) imem_rdata <= prog[imem_addr];
    if (dmem_rd) dmem_rdata <= rd_mem(dmem_addr);
    if (dmem_wr) begin
      mem[dmem_addr]    <= dmem_wdata;
      mvalid[dmem_addr] <= 1'b1;
    end
  end

  // reference model: m_st 0=run 1=halt 2=fault; m_ph = cycle within instruction
  int          m_st = 0;
  int          m_ph = 0;
  logic [10:0] m_pc = '0;
  logic [15:0] m_ir = '0;
  logic [2:0]  m_code = '0;
  logic [15:0] m_pend = '0;
  logic [15:0] m_ds [$];
  logic [10:0] m_rs [$];

  task automatic trap(input logic [2:0] c);
    m_st = 2;
    m_code = c;
  endtask

  function automatic bit is_bin(input logic [4:0] op);
    return (op >= 5'd8 && op <= 5'd12) || (MUL_EN && op == 5'h10);
  endfunction

  task automatic model_exec();
    logic [4:0]  op;
    logic [10:0] a;
    logic [15:0] t, n, r;
    int sz;
    op = m_ir[15:11];
    a  = m_ir[10:0];
    sz = m_ds.size();
    r  = '0;
    if (op == 5'h1F) m_st = 1;
    else if (op == 5'h00) begin end
    else if (op == 5'h01) begin
      if (sz == 32) trap(1); else m_ds.push_back({5'd0, a});
    end else if (op == 5'h02) begin
      if (sz == 32) trap(1);
      else begin m_pend = rd_mem(a); m_ph = 3; end
    end else if (op == 5'h03) begin
      if (sz < 1) trap(2); else void'(m_ds.pop_back());
    end else if (op == 5'h04) m_pc = a;
    else if (op == 5'h05) begin
      if (sz < 1) trap(2);
      else begin t = m_ds.pop_back(); if (t == 16'd0) m_pc = a; end
    end else if (op == 5'h06) begin
      if (m_rs.size() == 16) trap(3);
      else begin m_rs.push_back(m_pc); m_pc = a; end
    end else if (op == 5'h07) begin
      if (m_rs.size() == 0) trap(4); else m_pc = m_rs.pop_back();
    end else if (op == 5'h0D) begin
      if (sz < 1) trap(2); else m_ds[sz-1] = ~m_ds[sz-1];
    end else if (op == 5'h0E) begin
      if (sz < 1) trap(2);
      else if (sz == 32) trap(1);
      else m_ds.push_back(m_ds[sz-1]);
    end else if (is_bin(op)) begin
      if (sz < 2) trap(2);
      else begin
        t = m_ds.pop_back();
        n = m_ds.pop_back();
        case (op)
          5'h08:   r = 16'((int'(n) + int'(t)) % 65536);
          5'h09:   r = 16'((int'(n) - int'(t) + 65536) % 65536);
          5'h0A:   r = n & t;
          5'h0B:   r = n | t;
          5'h0C:   r = n ^ t;
          default: r = 16'((longint'(n) * longint'(t)) % 65536);
        endcase
        m_ds.push_back(r);
      end
    end else trap(5);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_st = 0; m_ph = 0; m_pc = '0; m_ir = '0; m_code = '0;
      m_ds.delete();
      m_rs.delete();
    end else if (m_st == 0) begin
      case (m_ph)
        0: m_ph = 1;
        1: begin m_ir = prog[m_pc]; m_pc = m_pc + 11'd1; m_ph = 2; end
        2: begin m_ph = 0; model_exec(); end
        default: begin m_ds.push_back(m_pend); m_ph = 0; end
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_cycle();
    logic e_ird, e_drd, e_dwr;
    logic [4:0] op;
    int sz;
    if (rst) begin
      chk("rst_imem_rd", 32'(imem_rd), 0);
      chk("rst_dmem_rd", 32'(dmem_rd), 0);
      chk("rst_dmem_wr", 32'(dmem_wr), 0);
      return;
    end
    sz = m_ds.size();
    op = m_ir[15:11];
    e_ird = (m_st == 0) && (m_ph == 0);
    e_drd = (m_st == 0) && (m_ph == 2) && (op == 5'h02) && (sz < 32);
    e_dwr = (m_st == 0) && (m_ph == 2) && (op == 5'h03) && (sz > 0);
    chk("imem_rd", 32'(imem_rd), 32'(e_ird));
    if (e_ird) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    chk("dmem_rd", 32'(dmem_rd), 32'(e_drd));
    chk("dmem_wr", 32'(dmem_wr), 32'(e_dwr));
    if (e_drd || e_dwr) chk("dmem_addr", 32'(dmem_addr), 32'(m_ir[10:0]));
    if (e_dwr) chk("dmem_wdata", 32'(dmem_wdata), 32'(m_ds[sz-1]));
    chk("halted", 32'(halted), 32'(m_st == 1));
    chk("fault", 32'(fault), 32'(m_st == 2));
    chk("fault_code", 32'(fault_code), 32'(m_code));
    chk("dsp", 32'(dsp), 32'(sz));
  endtask

  function automatic logic [15:0] dut_top();
    return dut.r_dstk[dut.r_dsp[4:0] - 5'd1];
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 64; i++) prog[i] = ins(5'h1F, 0);
  endtask

  task automatic go();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run(input int maxc, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(halted || fault) && cyc < maxc);
    if (!(halted || fault)) chk("timeout", 0, 1);
  endtask

  initial begin
    int cyc;
    int strobes;
    for (int i = 0; i < 2048; i++) prog[i] = '0;
    fork
      forever begin
        @(negedge clk);
        cmp_cycle();
      end
    join_none

    // 5-3 stored at address 7
    do_reset();
    prog[0] = ins(5'h01, 5); prog[1] = ins(5'h01, 3);
    prog[2] = ins(5'h09, 0); prog[3] = ins(5'h03, 7);
    prog[4] = ins(5'h1F, 0);
    @(negedge clk);
    chk("reset_dsp", 32'(dsp), 0);
    chk("reset_halted", 32'(halted), 0);
    chk("reset_fault_code", 32'(fault_code), 0);
    go();
    run(40, cyc);
    chk("sub_halt_cycle", 32'(cyc), 16);
    chk("sub_mem7", 32'(mem[7]), 16'h0002);
    chk("sub_dsp", 32'(dsp), 0);
    chk("sub_model_depth", 32'(m_ds.size()), 0);

    // JZ taken skips PUSHI 9
    do_reset();
    prog[0] = ins(5'h01, 0); prog[1] = ins(5'h05, 4);
    prog[2] = ins(5'h01, 9); prog[3] = ins(5'h1F, 0);
    prog[4] = ins(5'h01, 1); prog[5] = ins(5'h1F, 0);
    go();
    run(40, cyc);
    chk("jz_cycle", 32'(cyc), 13);
    chk("jz_dsp", 32'(dsp), 1);
    chk("jz_top", 32'(dut_top()), 16'h0001);
    chk("jz_model_top", 32'(m_ds[0]), 16'h0001);

    // CALL/RET
    do_reset();
    prog[0] = ins(5'h06, 3); prog[1] = ins(5'h1F, 0);
    prog[2] = ins(5'h00, 0); prog[3] = ins(5'h01, 16'hFF);
    prog[4] = ins(5'h07, 0);
    go();
    run(40, cyc);
    chk("call_cycle", 32'(cyc), 13);
    chk("call_halted", 32'(halted), 1);
    chk("call_dsp", 32'(dsp), 1);
    chk("call_top", 32'(dut_top()), 16'h00FF);

    // 33 pushes overflow a 32-entry stack
    do_reset();
    for (int i = 0; i < 33; i++) prog[i] = ins(5'h01, i);
    go();
    run(200, cyc);
    chk("ovf_cycle", 32'(cyc), 100);
    chk("ovf_fault", 32'(fault), 1);
    chk("ovf_code", 32'(fault_code), 1);
    chk("ovf_dsp", 32'(dsp), 32);
    strobes = 0;
    repeat (4) begin
      @(negedge clk);
      strobes += int'(imem_rd) + int'(dmem_rd) + int'(dmem_wr);
    end
    chk("ovf_no_strobes", 32'(strobes), 0);

    // ADD on empty stack
    do_reset();
    prog[0] = ins(5'h08, 0);
    go();
    run(20, cyc);
    chk("udf_cycle", 32'(cyc), 4);
    chk("udf_code", 32'(fault_code), 2);

    // illegal 0x15
    do_reset();
    prog[0] = ins(5'h15, 0);
    go();
    run(20, cyc);
    chk("ill15_code", 32'(fault_code), 5);

`ifdef STACK_CPU_MUL_EN
    do_reset();
    prog[0] = ins(5'h01, 300); prog[1] = ins(5'h01, 300);
    prog[2] = ins(5'h10, 0);   prog[3] = ins(5'h1F, 0);
    go();
    run(40, cyc);
    chk("mul_cycle", 32'(cyc), 13);
    chk("mul_top", 32'(dut_top()), 16'h5F90);
`else
    do_reset();
    prog[0] = ins(5'h10, 0);
    go();
    run(20, cyc);
    chk("ill10_code", 32'(fault_code), 5);
`endif

    // 17 nested calls overflow a 16-entry return stack
    do_reset();
    for (int i = 0; i < 17; i++) prog[i] = ins(5'h06, i + 1);
    go();
    run(100, cyc);
    chk("rovf_cycle", 32'(cyc), 52);
    chk("rovf_code", 32'(fault_code), 3);

    // JMP then RET with empty return stack
    do_reset();
    prog[0] = ins(5'h04, 5); prog[5] = ins(5'h07, 0);
    go();
    run(20, cyc);
    chk("rudf_cycle", 32'(cyc), 7);
    chk("rudf_code", 32'(fault_code), 4);

    // logic ops, DUP/NOT, wrap-around, JZ not taken then taken
    do_reset();
    prog[0]  = ins(5'h01, 16'hF0);  prog[1]  = ins(5'h01, 16'h3C);
    prog[2]  = ins(5'h0C, 0);       prog[3]  = ins(5'h0E, 0);
    prog[4]  = ins(5'h0D, 0);       prog[5]  = ins(5'h0B, 0);
    prog[6]  = ins(5'h01, 16'h123); prog[7]  = ins(5'h0A, 0);
    prog[8]  = ins(5'h01, 16'h124); prog[9]  = ins(5'h09, 0);
    prog[10] = ins(5'h0E, 0);       prog[11] = ins(5'h03, 20);
    prog[12] = ins(5'h01, 1);       prog[13] = ins(5'h08, 0);
    prog[14] = ins(5'h0E, 0);       prog[15] = ins(5'h03, 21);
    prog[16] = ins(5'h01, 5);       prog[17] = ins(5'h05, 0);
    prog[18] = ins(5'h05, 20);      prog[19] = ins(5'h01, 7);
    prog[20] = ins(5'h1F, 0);
    go();
    run(100, cyc);
    chk("mix_cycle", 32'(cyc), 61);
    chk("mix_mem20", 32'(mem[20]), 16'hFFFF);
    chk("mix_mem21", 32'(mem[21]), 16'h0000);
    chk("mix_dsp", 32'(dsp), 0);

    // reset during MEMRD of PUSHM
    do_reset();
    prog[0] = ins(5'h01, 1); prog[1] = ins(5'h02, 5);
    prog[2] = ins(5'h1F, 0);
    go();
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rstm_dsp_before", 32'(dsp), 1);
    chk("rstm_no_rd", 32'(dmem_rd), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstm_dsp", 32'(dsp), 0);
    chk("rstm_fetch", 32'(imem_rd), 1);
    chk("rstm_pc", 32'(imem_addr), 0);
    run(40, cyc);
    chk("rstm_halted", 32'(halted), 1);
    chk("rstm_dsp_end", 32'(dsp), 2);
    chk("rstm_top", 32'(dut_top()), 16'hC005);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stack_cpu_core.md
Name: stack_cpu_core

Overview:
Parametrised successor to the single-width stack CPU. One synchronous core containing the PC, IR, a data stack, a return stack, the ALU and the control FSM, with external program and data memory ports. Word width, address width and both stack depths are parameters. Adds what the earlier CPU lacked: overflow and underflow detection, illegal-opcode trapping, a conditional jump, and HALT/FAULT terminal states with status outputs.

Parameters:
DW, 16, data word width (>= 8)
AW, 11, program and data address width; instruction width = 5 + AW
DSTACK_DEPTH, 32, data stack entries (power of 2, >= 4)
RSTACK_DEPTH, 16, return stack entries (power of 2, >= 2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset
imem_addr  out  AW  program address
imem_rd  out  1  program read strobe
imem_rdata  in  5+AW  instruction, valid the cycle after imem_rd
dmem_addr  out  AW  data address
dmem_rd  out  1  data read strobe; dmem_rdata valid the next cycle
dmem_wr  out  1  data write strobe
dmem_wdata  out  DW  write data
dmem_rdata  in  DW  read data
halted  out  1  core is in HALT
fault  out  1  core is in FAULT
fault_code  out  3  1=dstack overflow, 2=dstack underflow, 3=rstack overflow, 4=rstack underflow, 5=illegal opcode
dsp  out  $clog2(DSTACK_DEPTH)+1  data stack occupancy

Behaviour:
- Interface: one clock domain (clk). Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset: PC=0, IR=0, both stacks empty, dsp=0, state=FETCH. All strobes, halted, fault and fault_code are 0. Reset asserted mid-instruction aborts it and no memory strobe is issued that cycle.
- Instruction format: opcode = instr[AW+4:AW]; operand = instr[AW-1:0]; immediates are zero-extended to DW.
- FSM states: FETCH, DECODE, EXEC, MEMRD, HALT, FAULT.
  - FETCH: imem_rd=1 and imem_addr=PC.
  - DECODE: latch IR from imem_rdata, then PC <= PC+1, wrapping modulo 2^AW.
  - EXEC: check stack preconditions; on violation go to FAULT, latch fault_code, and leave the stacks and PC unchanged. Otherwise execute, then return to FETCH (or to MEMRD for PUSHM).
  - MEMRD: push dmem_rdata, then go to FETCH.
- Instruction latency: 3 cycles; PUSHM takes 4.
- Opcodes (T = top of stack, N = next):
  - 00 NOP.
  - 01 PUSHI: push operand.
  - 02 PUSHM: dmem_rd=1 at operand in EXEC.
  - 03 POPM: dmem_wr=1, dmem_wdata=T, dmem_addr=operand, then pop.
  - 04 JMP: PC <= operand.
  - 05 JZ: pop T; if T==0 then PC <= operand.
  - 06 CALL: push PC (already incremented) onto the return stack; PC <= operand.
  - 07 RET: pop the return stack into PC.
  - 08 ADD, 09 SUB (N-T), 0A AND, 0B OR, 0C XOR: pop 2, push result, wrapping modulo 2^DW.
  - 0D NOT: replace T.
  - 0E DUP: push T.
  - 1F HALT.
  - Any other opcode: FAULT with code 5.
- Preconditions:
  - A push with dsp==DSTACK_DEPTH gives code 1.
  - A pop with fewer operands than needed gives code 2. Binary ops need 2 entries; NOT, DUP, POPM and JZ need 1.
  - CALL with the return stack full gives code 3.
  - RET with the return stack empty gives code 4.
- Binary ops change dsp by -1 in a single cycle; this is not treated as a pop followed by a push.
- HALT and FAULT are sticky until rst. In these states no strobes are issued and halted or fault is held at 1.

Optional Feature:
- Macro STACK_CPU_MUL_EN.
- Defined: opcode 10 is MUL. It pops 2 and pushes the low DW bits of N*T; 3-cycle latency; same underflow check as other binary ops.
- Undefined: opcode 10 is illegal and raises FAULT with code 5. No multiplier logic is synthesised.

Test Plan:
- Program PUSHI 5, PUSHI 3, SUB, POPM 7, HALT -> dmem write of 2 at address 7; dsp=0; halted=1 after 16 cycles from reset release.
- PUSHI 0, JZ 4, PUSHI 9, HALT, [4] PUSHI 1, HALT -> final T=1, dsp=1, and no push of 9.
- CALL 3, HALT, NOP, [3] PUSHI 0xFF, RET -> returns to address 1; halted=1, dsp=1, T=0xFF.
- Loop of 33 PUSHI with DSTACK_DEPTH=32 -> the 33rd gives fault=1, fault_code=1, dsp=32; further cycles show no strobes.
- ADD on an empty stack -> fault_code=2; opcode 0x15 -> fault_code=5. With STACK_CPU_MUL_EN, PUSHI 300, PUSHI 300, MUL -> T=0x5F90 (DW=16, 90000 mod 65536). Without the macro, opcode 0x10 -> fault_code=5.
- rst asserted during the MEMRD of a PUSHM -> next cycle PC=0, dsp=0, no stack write, and fetch restarts at address 0.
